// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a square frame streamed one row at a time.
// Even rows park pair maxima in a line buffer; odd rows finish each window against it.
module max_pool_2x2 #(
   parameter logic [5:0] IN_W = 6'd5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pass,
   input  logic               srt_pool,
   input  logic signed [15:0] in_data,
   output logic signed [15:0] out_data,
   output logic               out_valid,
   output logic               out_end
);

   localparam int W     = int'(IN_W);
   localparam int LB_N  = W / 2;
   localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

   localparam logic [6:0] COL_WRAP  = 7'(W + 1);
   localparam logic [6:0] COL_VALID = 7'(W);
   localparam logic [6:0] ROW_LAST  = 7'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [6:0]         r_col;
   logic [6:0]         r_row;
   logic signed [15:0] r_pair;
   logic signed [15:0] r_lb [LB_N];
   logic signed [15:0] r_out_data;
   logic               r_out_valid;
   logic               r_out_end;

   logic               w_slot;
   logic               w_wrap;
   logic               w_valid_col;
   logic               w_odd_slot;
   logic               w_lb_wr;
   logic               w_emit;
   logic [LB_AW-1:0]   w_lb_idx;
   logic signed [15:0] w_pmax;
   logic signed [15:0] w_win;

   function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
      return (a > b) ? a : b;
   endfunction

   assign w_wrap      = (r_col == COL_WRAP);
   assign w_valid_col = (r_col < COL_VALID);
   assign w_lb_idx    = r_col[LB_AW:1];
   assign w_pmax      = smax(r_pair, in_data);
   assign w_win       = smax(w_pmax, r_lb[w_lb_idx]);

   // An odd valid column closes a horizontal pair; odd IN_W leaves the last column unpaired.
   assign w_odd_slot  = w_slot && w_valid_col && r_col[0];
   assign w_lb_wr     = w_odd_slot && !r_row[0];
   assign w_emit      = w_odd_slot && r_row[0];

   always_comb begin
      w_state_nxt = r_state;
      w_slot      = 1'b0;
      case (r_state)
         IDLE: begin
            if (srt_pool) begin
               w_slot      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!srt_pool) begin
               w_state_nxt = DONE;
            end else begin
               w_slot = 1'b1;
               if (w_wrap && (r_row == ROW_LAST)) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_pair      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_end   <= 1'b0;
         for (int i = 0; i < LB_N; i++) r_lb[i] <= '0;
      end else if (pass) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_pair      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_end   <= 1'b0;
         for (int i = 0; i < LB_N; i++) r_lb[i] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_emit;
         r_out_end   <= (r_state == DONE);
         if (w_emit) begin
            r_out_data <= w_win;
         end
         if (w_slot) begin
            if (w_wrap) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? 7'd0 : r_row + 7'd1;
            end else begin
               r_col <= r_col + 7'd1;
            end
         end
         if (w_slot && w_valid_col && !r_col[0]) begin
            r_pair <= in_data;
         end
         if (w_lb_wr) begin
            r_lb[w_lb_idx] <= w_pmax;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_end   = r_out_end;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: one IN_W=4 instance and one default (IN_W=5) instance
// share stimulus; each scenario checks only the instance whose frame geometry it drives.
module tb_max_pool_2x2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               pass;
   logic               srt_pool;
   logic signed [15:0] in_data;
   logic signed [15:0] od4, od5;
   logic               ov4, ov5, oe4, oe5;

   always #5 clk = ~clk;

   max_pool_2x2 #(.IN_W(6'd4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .pass(pass), .srt_pool(srt_pool), .in_data(in_data),
      .out_data(od4), .out_valid(ov4), .out_end(oe4)
   );

   max_pool_2x2 u_dut5 (
      .clk(clk), .rst_n(rst_n), .pass(pass), .srt_pool(srt_pool), .in_data(in_data),
      .out_data(od5), .out_valid(ov5), .out_end(oe5)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic sel5 = 1'b0;

   logic signed [15:0] q_dat[$];
   int                 q_cyc[$];
   int                 e_cyc[$];
   logic signed [15:0] fr [0:24];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!sel5 && ov4) begin
         q_dat.push_back(od4);
         q_cyc.push_back(cyc);
      end
      if (sel5 && ov5) begin
         q_dat.push_back(od5);
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      q_dat.delete();
      q_cyc.delete();
      e_cyc.delete();
   endtask

   task automatic do_pass();
      pass = 1'b1;
      step();
      pass = 1'b0;
      clear_q();
   endtask

   // Drives up to nslots slots of a w-wide frame; records when each full window should emit.
   task automatic run_frame(input int w, input int nrows, input int nslots);
      int s = 0;
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < w + 2; c++) begin
            if (s < nslots) begin
               srt_pool = 1'b1;
               if (c < w) in_data = fr[r*w + c];
               if ((r % 2 == 1) && (c % 2 == 1) && (c < w) && (r < (w/2)*2))
                  e_cyc.push_back(cyc + 1);
               step();
               s++;
            end
         end
      end
      srt_pool = 1'b0;
   endtask

   task automatic check_out(input string tag, input int n,
                            input int v0, input int v1, input int v2, input int v3);
      int v[4];
      v = '{v0, v1, v2, v3};
      chk({tag, "_count"}, q_dat.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < q_dat.size()) begin
            chk($sformatf("%s_val%0d", tag, i), q_dat[i], v[i]);
            if (i < e_cyc.size())
               chk($sformatf("%s_lat%0d", tag, i), q_cyc[i], e_cyc[i]);
         end
      end
   endtask

   task automatic load4(input int a[16]);
      for (int i = 0; i < 16; i++) fr[i] = 16'(a[i]);
   endtask

   initial begin
      rst_n    = 1'b0;
      pass     = 1'b0;
      srt_pool = 1'b0;
      in_data  = '0;
      repeat (3) step();
      chk("rst_data4", od4, 0);
      chk("rst_valid4", ov4, 0);
      chk("rst_end4", oe4, 0);
      chk("rst_valid5", ov5, 0);
      chk("rst_end5", oe5, 0);
      rst_n = 1'b1;
      step();

      // Basic 4x4 frame
      load4('{1, 5, -3, 2, 4, 0, 7, -8, -1, -2, -3, -4, -5, -6, -7, -8});
      clear_q();
      run_frame(4, 4, 1000);
      step();
      step();
      check_out("basic", 4, 5, 7, -1, -3);
      chk("basic_end", oe4, 1);
      chk("basic_hold", od4, -3);

      // pass while done clears outputs next cycle
      pass = 1'b1;
      step();
      pass = 1'b0;
      chk("pass_end", oe4, 0);
      chk("pass_valid", ov4, 0);
      chk("pass_data", od4, 0);

      // pass wins over srt_pool; signed extremes
      load4('{-32768, -1, 100, 50, -2, -32767, -100, 200, 3, 9, -4, -9, 8, 1, -5, -6});
      clear_q();
      pass     = 1'b1;
      srt_pool = 1'b1;
      in_data  = 16'sd30000;
      step();
      pass = 1'b0;
      run_frame(4, 4, 1000);
      step();
      step();
      check_out("signed", 4, -1, 200, 9, -4);
      do_pass();

      // Default IN_W=5: last column and row dropped even when largest
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            fr[r*5 + c] = ((r == 4) || (c == 4)) ? 16'(1000 + r*10 + c) : 16'(r*10 + c);
      sel5 = 1'b1;
      clear_q();
      run_frame(5, 5, 1000);
      step();
      step();
      check_out("odd5", 4, 11, 13, 31, 33);
      chk("odd5_end", oe5, 1);
      do_pass();
      sel5 = 1'b0;

      // Async reset at row 1 col 2, then restart
      load4('{1, 5, -3, 2, 4, 0, 7, -8, -1, -2, -3, -4, -5, -6, -7, -8});
      clear_q();
      run_frame(4, 4, 8);
      srt_pool = 1'b1;
      in_data  = fr[6];
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", ov4, 0);
      chk("arst_data", od4, 0);
      srt_pool = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      clear_q();
      run_frame(4, 4, 1000);
      step();
      step();
      check_out("restart", 4, 5, 7, -1, -3);
      do_pass();

      // Early frame end after row 2; reassert ignored until pass
      run_frame(4, 4, 18);
      step();
      chk("early_end_lag", oe4, 0);
      step();
      chk("early_end", oe4, 1);
      srt_pool = 1'b1;
      in_data  = 16'sd12345;
      repeat (8) step();
      srt_pool = 1'b0;
      chk("early_end_hold", oe4, 1);
      check_out("early", 2, 5, 7, 0, 0);
      do_pass();
      chk("early_pass_end", oe4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 The block SHALL have parameter IN_W, default 6'd5, giving the width and height (samples) of the square convolution-result frame it consumes.
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port pass, input, 1, synchronous clear; while high, all state and outputs return to their reset values.
REQ-005 The block SHALL have port srt_pool, input, 1, frame-active level from the upstream array.
REQ-006 The block SHALL have port in_data, input, 16, signed convolution result, valid per the row-timing rule in REQ-009.
REQ-007 The block SHALL have port out_data, output, 16, signed pooled maximum.
REQ-008 The block SHALL have ports out_valid (output, 1, one-cycle strobe qualifying out_data) and out_end (output, 1, frame-complete level).

Function
REQ-009 Row timing SHALL be: while srt_pool=1, every cycle is one slot; each input row occupies IN_W+2 consecutive slots; slots 0..IN_W-1 carry valid samples; slots IN_W and IN_W+1 are idle (in_data held, ignored).
REQ-010 Counters SHALL be: col (0..IN_W+1) increments each RUN slot and wraps to 0 after IN_W+1; row (0..IN_W-1) increments on each col wrap.
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on the first cycle srt_pool=1, with that cycle being slot col=0,row=0 and in_data sampled in it.
REQ-012 RUN->DONE SHALL occur on the col wrap of row IN_W-1, or on any cycle srt_pool=0 while in RUN (early frame end); DONE SHALL hold until pass or rst_n.
REQ-013 Pooling SHALL be 2x2 window, stride 2, non-overlapping; all comparisons signed 16-bit; result SHALL be exactly one of the four inputs (no rounding or saturation).
REQ-014 On even col, the sample SHALL be held in a pair register; on the following odd col, the pair maximum SHALL be formed.
REQ-015 On an even row, the pair maximum SHALL be written to line buffer entry col/2 (IN_W/2 entries, floor).
REQ-016 On an odd row, the pair maximum SHALL be compared with line buffer entry col/2; the larger value SHALL be registered to out_data with out_valid=1 on the next cycle only.
REQ-017 Odd IN_W: the last column (col=IN_W-1, no partner) and the last row (row=IN_W-1) SHALL be discarded; no partial window is ever output.
REQ-018 Outputs per full frame SHALL be exactly floor(IN_W/2)^2, in raster order; latency from the sample completing a window to out_valid SHALL be 1 cycle.
REQ-019 out_data SHALL hold its last value when out_valid=0.
REQ-020 out_end SHALL rise on the cycle after entering DONE and stay high while in DONE.
REQ-021 srt_pool=0 in IDLE SHALL be ignored; srt_pool=1 in DONE SHALL be ignored (a new frame requires pass).
REQ-022 pass and srt_pool high together SHALL give priority to pass; the block SHALL remain in IDLE that cycle.

Reset
REQ-023 On rst_n=0 (asynchronous) or pass=1 (synchronous), the block SHALL set: FSM=IDLE, col=0, row=0, out_data=16'sd0, out_valid=0, out_end=0, pair register and line buffer=0.
REQ-024 Reset or pass mid-frame SHALL abort the frame; no out_valid SHALL follow it; the next srt_pool rise SHALL start a fresh frame at row 0, col 0.

Verification
REQ-025 IN_W=4, rows {1,5,-3,2},{4,0,7,-8},{-1,-2,-3,-4},{-5,-6,-7,-8} with 2 idle slots per row -> out_valid pulses carrying 5, 7, -1, -3, each one cycle after the window-completing sample; then out_end=1.
REQ-026 IN_W=5 (default), 25 samples all distinct -> exactly 4 outputs; column 4 and row 4 values never appear, even when they are the largest in the frame.
REQ-027 All-negative window {-32768,-1,-2,-32767} -> out_data=-1 (signed compare; no unsigned misordering).
REQ-028 Assert rst_n=0 during row 1, col 2, then restart the frame -> no out_valid before the restarted row 1; outputs match a clean run.
REQ-029 Drop srt_pool after row 2 of a 4-row frame -> DONE entered, out_end=1 the next cycle, no further out_valid; srt_pool reasserted -> ignored until pass=1.
REQ-030 pass=1 while out_end=1 -> out_end=0 and out_valid=0 the next cycle; a subsequent frame is processed normally.
